// File: rtl/game_pkg.sv
// Shared types and constants for the two-player bomb game.
// Round states, winner codes and grid geometry.
package game_pkg;

    localparam int GRID_DIM   = 16;
    localparam int GRID_CELLS = GRID_DIM * GRID_DIM;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INIT      = 3'd1,
        COUNTDOWN = 3'd2,
        PLAY      = 3'd3,
        PAUSED    = 3'd4,
        RESULT    = 3'd5
    } round_state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2,
        WIN_DRAW = 2'd3
    } winner_e;

    function automatic logic [7:0] sat_dec8(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Game-second prescaler: one-cycle tick every TICK_DIV clocks.
// clr restarts the second; hold freezes the count and masks the tick.
module sec_tick_gen #(
    parameter int TICK_DIV = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (!hold) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == LAST) && !hold;

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: start, countdown, play with hit detection, result hold.
// Optional pause support is built when ROUND_PAUSE_EN is defined.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV      = 30,
    parameter int COUNTDOWN_S   = 3,
    parameter int ROUND_S       = 180,
    parameter int RESULT_HOLD_S = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
`ifdef ROUND_PAUSE_EN
    input  logic                  i_pause,
`endif
    input  logic [GRID_CELLS-1:0] i_explode,
    input  logic [7:0]            i_p1_cor,
    input  logic [7:0]            i_p2_cor,
    output logic [2:0]            o_state,
    output logic                  o_play_en,
    output logic                  o_freeze,
    output logic                  o_clear_map,
    output logic [3:0]            o_countdown,
    output logic [7:0]            o_time_left,
    output logic [1:0]            o_winner,
    output logic                  o_round_done
);

    localparam logic [3:0] CD_INIT   = 4'(COUNTDOWN_S);
    localparam logic [7:0] TL_INIT   = 8'(ROUND_S);
    localparam logic [3:0] HOLD_LAST = 4'(RESULT_HOLD_S - 1);

    round_state_e state_q, state_d;
    winner_e      win_q, win_d;
    logic [3:0]   cd_q, cd_d;
    logic [7:0]   tl_q, tl_d;
    logic [3:0]   hc_q, hc_d;
    logic         done_q, done_d;

    logic sec_tick;
    logic tick_clr;
    logic tick_hold;
    logic pause_req;
    logic pause_swap;
    logic hit1;
    logic hit2;

`ifdef ROUND_PAUSE_EN
    assign pause_req = i_pause;
`else
    assign pause_req = 1'b0;
`endif

    assign hit1 = i_explode[i_p1_cor];
    assign hit2 = i_explode[i_p2_cor];

    // Pausing must keep the partial second, so PLAY<->PAUSED does not clear.
    assign pause_swap = (state_q == PLAY && state_d == PAUSED)
                     || (state_q == PAUSED && state_d == PLAY);
    assign tick_clr   = (state_d != state_q) && !pause_swap;
    assign tick_hold  = (state_q == PAUSED)
                     || (state_q == PLAY && pause_req);

    sec_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (tick_clr),
        .hold (tick_hold),
        .tick (sec_tick)
    );

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cd_d    = cd_q;
        tl_d    = tl_q;
        hc_d    = hc_q;
        unique case (state_q)
            IDLE: begin
                win_d = WIN_NONE;
                cd_d  = 4'd0;
                tl_d  = 8'd0;
                hc_d  = 4'd0;
                if (i_start) state_d = INIT;
            end
            INIT: begin
                state_d = COUNTDOWN;
                cd_d    = CD_INIT;
            end
            COUNTDOWN: begin
                if (sec_tick) begin
                    cd_d = (cd_q == 4'd0) ? 4'd0 : cd_q - 4'd1;
                    if (cd_q <= 4'd1) begin
                        state_d = PLAY;
                        tl_d    = TL_INIT;
                    end
                end
            end
            PLAY: begin
                if (hit1 || hit2) begin
                    state_d = RESULT;
                    hc_d    = 4'd0;
                    if (hit1 && hit2) win_d = WIN_DRAW;
                    else if (hit1)    win_d = WIN_P2;
                    else              win_d = WIN_P1;
                end else if (pause_req) begin
                    state_d = PAUSED;
                end else if (sec_tick) begin
                    tl_d = sat_dec8(tl_q);
                    if (tl_q <= 8'd1) begin
                        state_d = RESULT;
                        hc_d    = 4'd0;
                        win_d   = WIN_DRAW;
                    end
                end
            end
            PAUSED: begin
                if (pause_req) state_d = PLAY;
            end
            RESULT: begin
                if (sec_tick) begin
                    hc_d = hc_q + 4'd1;
                    if (hc_q >= HOLD_LAST) begin
                        state_d = IDLE;
                        win_d   = WIN_NONE;
                        tl_d    = 8'd0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign done_d = (state_d == RESULT) && (state_q != RESULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= WIN_NONE;
            cd_q    <= 4'd0;
            tl_q    <= 8'd0;
            hc_q    <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cd_q    <= cd_d;
            tl_q    <= tl_d;
            hc_q    <= hc_d;
            done_q  <= done_d;
        end
    end

    assign o_state      = state_q;
    assign o_play_en    = (state_q == PLAY);
    assign o_freeze     = (state_q != PLAY);
    assign o_clear_map  = (state_q == INIT);
    assign o_countdown  = cd_q;
    assign o_time_left  = tl_q;
    assign o_winner     = win_q;
    assign o_round_done = done_q;

endmodule
